ram_copy_engine: RTL and testbench
==================================

# ram_copy_engine

Memory-to-memory copy initiator for the 256 x 8 dual-port RAM. It drives the RAM's port A as a read-only stream and port B as a write-only stream, moving `len` bytes from `src_addr` to `dst_addr` at one byte per clock. Overlapping regions are handled with memmove semantics. It sits between a control master (CPU-side register or sequencer) and the RAM's port signals, and is the only driver of both RAM ports while `busy` is high.

## Interface
- `ADDR_W`, default 8: RAM address width; the address space is 2^ADDR_W words.
- `DATA_W`, default 8: RAM data width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset; one clock; reset is asynchronous and active-low.
- `start`  in  1: request a copy; sampled only in IDLE.
- `src_addr`  in  ADDR_W: first source address.
- `dst_addr`  in  ADDR_W: first destination address.
- `len`  in  ADDR_W+1: byte count; 0 = no-op; values >256 clamp to 256.
- `busy`  out  1: copy in progress.
- `done`  out  1: single-cycle completion pulse.
- `ram_addr_A`  out  ADDR_W: RAM port A address (read).
- `ram_wr_en_A`  out  1: tied 0; port A never writes.
- `ram_q_A`  in  DATA_W: RAM port A registered read data.
- `ram_addr_B`  out  ADDR_W: RAM port B address (write).
- `ram_data_B`  out  DATA_W: RAM port B write data; combinational pass-through of `ram_q_A`.
- `ram_wr_en_B`  out  1: RAM port B write enable.

## Operation
- States: IDLE, READ, LAST, DONE.
- IDLE: `start`=1 latches `src_addr`, `dst_addr`, and clamped `len`, and selects the direction.
  - If the clamped length is 0, go to DONE.
  - Otherwise go to READ.
  - `start` while not in IDLE is ignored.
- Direction: descending if `(dst_addr - src_addr) mod 256 < len` and `dst_addr != src_addr`; ascending otherwise.
  - Ascending order: `src+i`, `dst+i`, for i = 0..N-1.
  - Descending order: `src+N-1-i`, `dst+N-1-i`.
  - All address arithmetic wraps modulo 2^ADDR_W.
- READ: one read is issued per cycle on `ram_addr_A`. From the second READ cycle on, the previous read is written the same cycle (`ram_wr_en_B`=1, `ram_addr_B` = matching dst). After the Nth read is issued, go to LAST.
- LAST: final write only, then go to DONE.
- DONE: `done`=1, `busy`=0, then go to IDLE.
- RAM same-address read/write in one cycle returns old data. The pipeline relies on this, so dst = src+1 ascending is correct.

## Timing
- Reset values:
  - `busy`, `done`, and `ram_wr_en_B` = 0.
  - `ram_addr_A` and `ram_addr_B` = 0.
  - `ram_wr_en_A` = 0 always.
  - State = IDLE.
- `start` is sampled at edge E0. READ occupies cycles 1..N, LAST is cycle N+1, and DONE is cycle N+2.
- `busy`=1 in cycles 1..N+1. `done`=1 in cycle N+2 only.
- Read issued in cycle k gives `ram_q_A` valid in cycle k+1, which is written at the end of cycle k+1 (writes in cycles 2..N+1).
- `len`=0: `done` in cycle 1, `busy` never asserted, no writes.
- Back-to-back operation: `start` is accepted in the cycle after DONE (IDLE). Throughput is N+3 cycles per copy.
- Reset mid-copy: all outputs are cleared immediately (async), and `ram_wr_en_B` drops with no further write. The destination is left partially written. No `done` pulse is generated.
- All outputs except `ram_data_B` are registered.

## Structure
- Shared package `ram_copy_pkg`:
  - State enum {IDLE, READ, LAST, DONE}.
  - `ADDR_W`/`DATA_W` defaults.
  - `MAX_LEN` = 2^ADDR_W.
- Single flat module. The address/count generator is simple enough to stay inline; no sub-module.

## Test plan
- Preload RAM[i]=i. Copy src=0x10, dst=0x80, len=16. Expect:
  - RAM[0x80..0x8F] = 0x10..0x1F.
  - `done` exactly 18 cycles after the `start` edge.
  - `busy` high for 17 cycles.
- Overlap forward: src=0x20, dst=0x22, len=8 (descending chosen). Expect RAM[0x22..0x29] = old 0x20..0x27.
- Overlap backward: src=0x22, dst=0x20, len=8 (ascending). Expect RAM[0x20..0x27] = old 0x22..0x29.
- Wrap: src=0xFC, dst=0x04, len=6. Expect RAM[0x04..0x09] = old {FC,FD,FE,FF,00,01}.
- len=0: expect `done` one cycle after `start`, no `ram_wr_en_B` pulses. Also, `start` pulsed mid-copy is ignored.
- Reset: assert `rst_n`=0 in cycle 5 of a len=16 copy. Expect:
  - All outputs 0 immediately.
  - Exactly 3 writes landed.
  - Engine in IDLE afterwards, accepting a new `start`.

Source files
------------

// File: rtl/ram_copy_pkg.sv
// rtl/ram_copy_pkg.sv - shared types and defaults for the RAM copy engine
package ram_copy_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int MAX_LEN    = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LAST,
        DONE
    } copy_state_t;

endpackage

// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - memmove-style copy streaming RAM port A reads into port B writes
module ram_copy_engine
    import ram_copy_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr_A,
    output logic              ram_wr_en_A,
    input  logic [DATA_W-1:0] ram_q_A,
    output logic [ADDR_W-1:0] ram_addr_B,
    output logic [DATA_W-1:0] ram_data_B,
    output logic              ram_wr_en_B
);

    localparam logic [ADDR_W:0] MAX_N   = (ADDR_W+1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);

    copy_state_t       state;
    logic [ADDR_W:0]   n_reg;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W-1:0] dst_ptr;
    logic              desc_reg;

    logic [ADDR_W:0]   n_clamp;
    logic [ADDR_W-1:0] diff;
    logic              descend;
    logic [ADDR_W-1:0] last_off;
    logic [ADDR_W-1:0] src_first;
    logic [ADDR_W-1:0] dst_first;

    assign ram_wr_en_A = 1'b0;
    assign ram_data_B  = ram_q_A;

    // Descend when the destination starts inside the source window, so no
    // source byte is overwritten before it has been read.
    always_comb begin
        n_clamp   = (len > MAX_N) ? MAX_N : len;
        diff      = dst_addr - src_addr;
        descend   = ({1'b0, diff} < n_clamp) && (diff != '0);
        last_off  = ADDR_W'(n_clamp - ONE_CNT);
        src_first = descend ? src_addr + last_off : src_addr;
        dst_first = descend ? dst_addr + last_off : dst_addr;
    end

    function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a, input logic dn);
        return dn ? a - ADDR_W'(1) : a + ADDR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_addr_A  <= '0;
            ram_addr_B  <= '0;
            ram_wr_en_B <= 1'b0;
            n_reg       <= '0;
            rd_cnt      <= '0;
            dst_ptr     <= '0;
            desc_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n_reg    <= n_clamp;
                        desc_reg <= descend;
                        if (n_clamp == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy       <= 1'b1;
                            ram_addr_A <= src_first;
                            dst_ptr    <= dst_first;
                            rd_cnt     <= ONE_CNT;
                            state      <= READ;
                        end
                    end
                end
                READ: begin
                    // Write lags the read by one cycle to match the RAM's registered output.
                    ram_wr_en_B <= 1'b1;
                    ram_addr_B  <= dst_ptr;
                    dst_ptr     <= step(dst_ptr, desc_reg);
                    if (rd_cnt == n_reg) begin
                        state <= LAST;
                    end else begin
                        ram_addr_A <= step(ram_addr_A, desc_reg);
                        rd_cnt     <= rd_cnt + ONE_CNT;
                    end
                end
                LAST: begin
                    ram_wr_en_B <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - directed bench for ram_copy_engine against a 256x8 dual-port RAM model
module tb_ram_copy_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [8:0] len;
    logic       busy;
    logic       done;
    logic [7:0] ram_addr_A;
    logic       ram_wr_en_A;
    logic [7:0] ram_q_A;
    logic [7:0] ram_addr_B;
    logic [7:0] ram_data_B;
    logic       ram_wr_en_B;

    logic       init_req;
    logic [7:0] mem [256];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .ram_addr_A  (ram_addr_A),
        .ram_wr_en_A (ram_wr_en_A),
        .ram_q_A     (ram_q_A),
        .ram_addr_B  (ram_addr_B),
        .ram_data_B  (ram_data_B),
        .ram_wr_en_B (ram_wr_en_B)
    );

    // Dual-port RAM: registered read, same-address read during write returns old data.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (ram_wr_en_B) begin
            mem[ram_addr_B] <= ram_data_B;
        end
        ram_q_A <= mem[ram_addr_A];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] ln,
                            input bit glitch, input string tag);
        logic [7:0] old  [256];
        logic [7:0] expm [256];
        int n, done_cyc, done_cnt, busy_cnt, wr_cnt;
        n = (ln > 9'd256) ? 256 : int'(ln);
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; wr_cnt = 0;
        for (int i = 0; i < 256; i++) old[i] = mem[i];
        for (int i = 0; i < 256; i++) expm[i] = old[i];
        for (int i = 0; i < n; i++) expm[8'(dst + i)] = old[8'(src + i)];

        src_addr = src; dst_addr = dst; len = ln; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= n + 6; cyc++) begin
            if (glitch && cyc == 2) begin
                start = 1'b1; src_addr = 8'h00; dst_addr = 8'h01; len = 9'd5;
            end
            if (glitch && cyc == 3) start = 1'b0;
            if (busy) busy_cnt++;
            if (ram_wr_en_B) wr_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            @(negedge clk);
        end
        check({tag, "_done_cycle"}, done_cyc, (n == 0) ? 1 : n + 2);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, (n == 0) ? 0 : n + 1);
        check({tag, "_writes"}, wr_cnt, n);
        for (int i = 0; i < 256; i++)
            check($sformatf("%s_mem%02h", tag, i), mem[i], expm[i]);
    endtask

    int changed;

    initial begin
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0; init_req = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en_B", ram_wr_en_B, 0);
        check("rst_addr_A", ram_addr_A, 0);
        check("rst_addr_B", ram_addr_B, 0);
        check("rst_wr_en_A", ram_wr_en_A, 0);
        @(negedge clk);
        rst_n = 1'b1;
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        @(negedge clk);

        run_copy(8'h10, 8'h80, 9'd16, 1'b0, "basic");
        for (int i = 0; i < 16; i++) check($sformatf("basic_hand%0d", i), mem[8'h80 + i], 8'h10 + i);

        run_copy(8'h20, 8'h22, 9'd8, 1'b0, "ovl_fwd");
        for (int i = 0; i < 8; i++) check($sformatf("fwd_hand%0d", i), mem[8'h22 + i], 8'h20 + i);

        run_copy(8'h22, 8'h20, 9'd8, 1'b0, "ovl_bwd");
        for (int i = 0; i < 8; i++) check($sformatf("bwd_hand%0d", i), mem[8'h20 + i], 8'h20 + i);

        run_copy(8'hFC, 8'h04, 9'd6, 1'b0, "wrap");
        check("wrap_hand0", mem[8'h04], 8'hFC);
        check("wrap_hand1", mem[8'h05], 8'hFD);
        check("wrap_hand2", mem[8'h06], 8'hFE);
        check("wrap_hand3", mem[8'h07], 8'hFF);
        check("wrap_hand4", mem[8'h08], 8'h00);
        check("wrap_hand5", mem[8'h09], 8'h01);

        run_copy(8'h30, 8'h90, 9'd0, 1'b0, "len0");
        run_copy(8'h30, 8'h90, 9'd4, 1'b1, "ignore_start");
        run_copy(8'h00, 8'h00, 9'h1FF, 1'b0, "clamp");

        src_addr = 8'h40; dst_addr = 8'hC0; len = 9'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_wr_en_B", ram_wr_en_B, 0);
        check("midrst_addr_A", ram_addr_A, 0);
        check("midrst_addr_B", ram_addr_B, 0);
        check("midrst_wr_en_A", ram_wr_en_A, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        changed = 0;
        for (int i = 0; i < 16; i++) if (mem[8'hC0 + i] !== 8'(8'hC0 + i)) changed++;
        check("midrst_writes", changed, 3);
        check("midrst_c0", mem[8'hC0], 8'h40);
        check("midrst_c1", mem[8'hC1], 8'h41);
        check("midrst_c2", mem[8'hC2], 8'h42);
        check("midrst_c3", mem[8'hC3], 8'hC3);

        run_copy(8'h50, 8'h60, 9'd3, 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
